// File: rtl/accum_warp_linear_serializer_pkg.sv
// Shared constants and helpers for the linear-address serializer slice.
package accum_warp_linear_serializer_pkg;

    localparam int N_CFG_DEF = 4;
    localparam int ABW_DEF   = 8;

    // Width of a round-robin pointer over n channels; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/accum_warp_linear_serializer_if.sv
// Bundle of per-config source channels plus the single tagged output stream.
interface accum_warp_linear_serializer_if
    import accum_warp_linear_serializer_pkg::*;
#(
    parameter  int N_CFG   = N_CFG_DEF,
    parameter  int ABW     = ABW_DEF,
    localparam int NCFG_BW = $clog2(N_CFG + 1)
);
    logic [N_CFG-1:0]   linear_rdys;
    logic [N_CFG-1:0]   linear_acks;
    logic [ABW-1:0]     i_linears [N_CFG];
    logic               dst_rdy;
    logic               dst_ack;
    logic [ABW-1:0]     o_linear;
    logic [NCFG_BW-1:0] o_linear_id;

    // Serializer side: consumes source channels, produces the tagged stream.
    modport slave (
        input  linear_rdys, i_linears, dst_ack,
        output linear_acks, dst_rdy, o_linear, o_linear_id
    );

    // Environment side: drives the sources and the downstream accept.
    modport master (
        output linear_rdys, i_linears, dst_ack,
        input  linear_acks, dst_rdy, o_linear, o_linear_id
    );
endinterface

// File: rtl/accum_warp_linear_serializer_rr_pick.sv
// Round-robin one-hot picker: lowest requester at or after ptr, searched cyclically.
module rr_pick_one_hot
    import accum_warp_linear_serializer_pkg::*;
#(
    parameter  int N   = 4,
    localparam int PW  = ptr_width(N),
    localparam int PW2 = $clog2(2 * N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    logic [N-1:0]   hi_mask_s;
    logic [2*N-1:0] dbl_s;
    logic           found_s;
    logic [PW2-1:0] pos_s;

    // Upper copy holds all requests, lower copy only those at/after ptr, so the
    // lowest set bit of the doubled vector is the cyclic winner.
    always_comb begin
        hi_mask_s = {N{1'b0}};
        dbl_s     = {(2*N){1'b0}};
        found_s   = 1'b0;
        pos_s     = {PW2{1'b0}};
        idx_o     = {PW{1'b0}};
        gnt_o     = {N{1'b0}};
        any_o     = |req_i;
        for (int j = 0; j < N; j++) begin
            hi_mask_s[j] = (j >= int'(ptr_i));
        end
        dbl_s = {req_i, req_i & hi_mask_s};
        for (int j = 0; j < 2 * N; j++) begin
            if (dbl_s[j] && !found_s) begin
                found_s = 1'b1;
                pos_s   = PW2'(j);
            end else begin
                found_s = found_s;
            end
        end
        if (pos_s >= PW2'(N)) begin
            idx_o = PW'(pos_s - PW2'(N));
        end else begin
            idx_o = PW'(pos_s);
        end
        if (any_o) begin
            gnt_o[idx_o] = 1'b1;
        end else begin
            gnt_o = {N{1'b0}};
        end
    end

endmodule

// File: rtl/accum_warp_linear_serializer.sv
// Serializes N_CFG per-config linear address channels into one (linear, id)
// stream through a single registered stage with round-robin arbitration.
module accum_warp_linear_serializer
    import accum_warp_linear_serializer_pkg::*;
#(
    parameter  int N_CFG   = N_CFG_DEF,
    parameter  int ABW     = ABW_DEF,
    localparam int NCFG_BW = $clog2(N_CFG + 1),
    localparam int PW      = ptr_width(N_CFG)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    accum_warp_linear_serializer_if.slave  sif
);

    logic [PW-1:0]      ptr_q, ptr_d;
    logic               dst_rdy_q, dst_rdy_d;
    logic [ABW-1:0]     o_linear_q;
    logic [NCFG_BW-1:0] o_linear_id_q;

    logic [N_CFG-1:0]   win_oh_s;
    logic [PW-1:0]      win_idx_s;
    logic               any_s;
    logic               can_load_s;
    logic               grant_s;
    logic [N_CFG-1:0]   acks_s;

    rr_pick_one_hot #(.N(N_CFG)) u_pick (
        .req_i (sif.linear_rdys),
        .ptr_i (ptr_q),
        .gnt_o (win_oh_s),
        .idx_o (win_idx_s),
        .any_o (any_s)
    );

    // Grant whenever the stage is empty or draining; suppressed while in reset
    // so no source sees an ack that the discarded stage would never deliver.
    always_comb begin
        can_load_s = !dst_rdy_q || sif.dst_ack;
        grant_s    = can_load_s && any_s && i_rst;
        acks_s     = {N_CFG{1'b0}};
        ptr_d      = ptr_q;
        dst_rdy_d  = dst_rdy_q;
        if (grant_s) begin
            acks_s    = win_oh_s;
            dst_rdy_d = 1'b1;
            if (win_idx_s == PW'(N_CFG - 1)) begin
                ptr_d = {PW{1'b0}};
            end else begin
                ptr_d = win_idx_s + PW'(1'b1);
            end
        end else if (sif.dst_ack) begin
            dst_rdy_d = 1'b0;
        end else begin
            dst_rdy_d = dst_rdy_q;
        end
    end

    // Control state: output-valid flag and round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            dst_rdy_q <= 1'b0;
            ptr_q     <= {PW{1'b0}};
        end else begin
            dst_rdy_q <= dst_rdy_d;
            ptr_q     <= ptr_d;
        end
    end

    // Payload stage loads only on a grant and otherwise holds its last value.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_linear_q    <= {ABW{1'b0}};
            o_linear_id_q <= {NCFG_BW{1'b0}};
        end else if (grant_s) begin
            o_linear_q    <= sif.i_linears[win_idx_s];
            o_linear_id_q <= NCFG_BW'(win_idx_s);
        end
    end

    assign sif.linear_acks = acks_s;
    assign sif.dst_rdy     = dst_rdy_q;
    assign sif.o_linear    = o_linear_q;
    assign sif.o_linear_id = o_linear_id_q;

endmodule

// File: tb/tb_accum_warp_linear_serializer.sv
// Directed bench for accum_warp_linear_serializer (N_CFG=4, ABW=8).
module tb_accum_warp_linear_serializer;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [7:0] lin_tab [4];

    accum_warp_linear_serializer_if #(.N_CFG(4), .ABW(8)) bus ();

    accum_warp_linear_serializer #(.N_CFG(4), .ABW(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .sif   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic rdy, input logic [7:0] lin, input logic [2:0] id);
        check_eq({tag, "_rdy"}, 32'(bus.dst_rdy), 32'(rdy));
        check_eq({tag, "_lin"}, 32'(bus.o_linear), 32'(lin));
        check_eq({tag, "_id"},  32'(bus.o_linear_id), 32'(id));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        lin_tab[0] = 8'h11;
        lin_tab[1] = 8'h5A;
        lin_tab[2] = 8'h33;
        lin_tab[3] = 8'h44;
        for (int i = 0; i < 4; i++) bus.i_linears[i] = lin_tab[i];
        rst = 1'b0;
        bus.linear_rdys = 4'b1111;
        bus.dst_ack = 1'b0;
        #3;
        check_out("reset", 1'b0, 8'h00, 3'd0);
        check_eq("reset_acks", 32'(bus.linear_acks), 32'h0);
        bus.linear_rdys = 4'b0000;
        cyc();
        rst = 1'b1;

        // All channels requesting: 0,1,2,3,0.
        bus.linear_rdys = 4'b1111;
        bus.dst_ack = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check_eq("all_acks", 32'(bus.linear_acks), 32'(4'b0001 << (k % 4)));
            cyc();
            check_out("all", 1'b1, lin_tab[k % 4], 3'(k % 4));
        end

        // Single channel 1, downstream always accepting (ptr=1 here).
        bus.linear_rdys = 4'b0010;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq("single_acks", 32'(bus.linear_acks), 32'h2);
            cyc();
            check_out("single", 1'b1, 8'h5A, 3'd1);
        end

        // Backpressure: load ch2, then stall three cycles.
        bus.linear_rdys = 4'b0100;
        #1;
        check_eq("bp_load_acks", 32'(bus.linear_acks), 32'h4);
        cyc();
        check_out("bp_load", 1'b1, 8'h33, 3'd2);
        bus.dst_ack = 1'b0;
        bus.linear_rdys = 4'b1011;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq("bp_acks", 32'(bus.linear_acks), 32'h0);
            cyc();
            check_out("bp_hold", 1'b1, 8'h33, 3'd2);
        end
        bus.dst_ack = 1'b1;
        #1;
        check_eq("bp_rel_acks", 32'(bus.linear_acks), 32'h8);
        cyc();
        check_out("bp_rel", 1'b1, 8'h44, 3'd3);

        // Pointer wrap: drive ptr to 3, then 0001 -> ch0, then 0101 -> ch2.
        bus.linear_rdys = 4'b0100;
        #1;
        check_eq("wrap_pre_acks", 32'(bus.linear_acks), 32'h4);
        cyc();
        bus.linear_rdys = 4'b0001;
        #1;
        check_eq("wrap_acks", 32'(bus.linear_acks), 32'h1);
        cyc();
        check_out("wrap", 1'b1, 8'h11, 3'd0);
        bus.linear_rdys = 4'b0101;
        #1;
        check_eq("wrap2_acks", 32'(bus.linear_acks), 32'h4);
        cyc();
        check_out("wrap2", 1'b1, 8'h33, 3'd2);

        // Drain to empty.
        bus.linear_rdys = 4'b0000;
        #1;
        check_eq("drain_acks", 32'(bus.linear_acks), 32'h0);
        cyc();
        check_out("drain", 1'b0, 8'h33, 3'd2);
        cyc();
        check_out("idle", 1'b0, 8'h33, 3'd2);

        // Reset mid-stream with id 3 pending (ptr=3).
        bus.linear_rdys = 4'b1000;
        #1;
        check_eq("mid_acks", 32'(bus.linear_acks), 32'h8);
        cyc();
        check_out("mid", 1'b1, 8'h44, 3'd3);
        bus.linear_rdys = 4'b1111;
        bus.dst_ack = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 8'h00, 3'd0);
        check_eq("async_rst_acks", 32'(bus.linear_acks), 32'h0);
        cyc();
        rst = 1'b1;
        bus.dst_ack = 1'b1;
        #1;
        check_eq("post_rst_acks", 32'(bus.linear_acks), 32'h1);
        cyc();
        check_out("post_rst", 1'b1, 8'h11, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/accum_warp_linear_serializer.md
Name: accum_warp_linear_serializer

Overview:
- Transmit-side counterpart of the per-config linear collector: gathers N_CFG per-config linear addresses, each on its own rdy/ack channel, into one tagged stream (linear, id).
- Round-robin arbitration and a single registered output stage give full throughput: one transfer per cycle.
- Sits between per-config address generators and a collector or consumer that takes (i_linear, i_linear_id).

Parameters:
- N_CFG, Default::N_CFG, number of config channels.
- ABW, Default::ABW, linear address width.
- NCFG_BW (derived, localparam), $clog2(N_CFG+1), id width; matches the collector's id port.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  asynchronous active-low reset.
- linear_rdys  input  N_CFG  per-channel valid.
- linear_acks  output  N_CFG  per-channel accept; one-hot or zero; combinational.
- i_linears  input  ABW x N_CFG (unpacked [N_CFG])  per-channel address.
- dst_rdy  output  1  output stage holds valid data.
- dst_ack  input  1  downstream accepts; only legal while dst_rdy=1.
- o_linear  output  ABW  registered address.
- o_linear_id  output  NCFG_BW  registered channel index of o_linear.

Behaviour:
- Reset (async, i_rst=0): dst_rdy=0, o_linear=0, o_linear_id=0, rr pointer=0. linear_acks=0 while in reset.
- Handshake: the codebase rdyack rules apply. A source holds rdy and data stable until acked. A transfer occurs in any cycle where rdy and ack are both 1.
- can_load = !dst_rdy || dst_ack (stage empty, or being drained this cycle).
- Arbitration (combinational):
  - Winner = lowest index i, searched cyclically from ptr, with linear_rdys[i]=1.
  - linear_acks = onehot(winner) when can_load and any rdy is set; otherwise 0.
  - linear_acks[i]=1 never occurs with linear_rdys[i]=0.
- On a grant, at the next edge:
  - o_linear <= i_linears[winner]; o_linear_id <= winner.
  - ptr <= winner+1, wrapping N_CFG-1 -> 0.
- Latency: 1 cycle from grant to dst_rdy.
- dst_rdy next state: 1 if a grant occurs; else 0 if dst_ack; else hold.
- o_linear and o_linear_id load only on a grant (clock-gated). They hold while dst_rdy=1 and dst_ack=0.
- Simultaneous dst_ack and grant: drain and reload in the same cycle. dst_rdy stays 1; no bubble.
- Backpressure (dst_rdy=1, dst_ack=0): all linear_acks=0; ptr holds.
- No requests: ptr holds; dst_rdy drops after the pending ack.
- Fairness: every asserted channel is served within N_CFG grants.
- N_CFG=1: ptr is constant 0; the block degenerates to a registered slice.
- Reset mid-transfer: the pending output is discarded. Sources whose ack was not yet issued keep their rdy asserted.

Decomposition:
- N_CFG and ABW defaults come from the Default package; TauCfg is imported for shared types. No new package content.
- One natural sub-module: rr_pick_one_hot (parameter N).
  - Inputs: req[N], ptr.
  - Outputs: one-hot grant, grant index, any.
  - Implementation: double-width masked priority encode.

Test Plan (N_CFG=4, ABW=8 unless stated):
- Single channel, no backpressure: rdys=0010 held, i_linears[1]=0x5A, dst_ack tied 1. Required: linear_acks=0010 every cycle; o_linear=0x5A, id=1 from cycle 1; dst_rdy stays 1.
- All channels requesting: rdys=1111, dst_ack=1. Required: ids in order 0,1,2,3,0, one per cycle; linear_acks rotate 0001,0010,0100,1000.
- Backpressure: load id 2 (0x33), then hold dst_ack=0 for 3 cycles with rdys=1011. Required: linear_acks=0; o_linear=0x33 and id=2 stable. On the dst_ack cycle, grant ch3 (ptr=3), and dst_rdy stays 1.
- Pointer wrap: ptr=3, rdys=0001. Required: grant ch0 and ptr becomes 1. Then with rdys=0101, grant ch2.
- Drain to empty: one request, then rdys=0 with dst_ack=1. Required: dst_rdy falls the cycle after the ack; o_linear keeps its last value.
- Reset mid-stream: assert i_rst=0 while dst_rdy=1 and id=3. Required: asynchronously dst_rdy=0, o_linear=0, id=0, linear_acks=0. After release with rdys=1111, the first grant is ch0.
